// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: directions, FSM states, datapath widths
// and the reverse-direction helper.
package snake_pkg;

   localparam int unsigned COORD_W = 10;
   localparam int unsigned LEN_W   = 7;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_e;

   // Opposite directions differ only in bit 1 of the encoding.
   function automatic dir_e reverse_dir(input dir_e d);
      return dir_e'(d ^ 2'd2);
   endfunction

endpackage

// File: rtl/snake_body_if.sv
// Signal bundle between the snake body stage, the controls and the fruit stage.
interface snake_body_if #(
   parameter int unsigned MAX_LEN = 30
);

   logic                                  start;
   logic [1:0]                            dir_req;
   logic                                  dir_valid;
   logic                                  grow;
   logic [MAX_LEN*snake_pkg::COORD_W-1:0] body_x;
   logic [MAX_LEN*snake_pkg::COORD_W-1:0] body_y;
   logic [snake_pkg::LEN_W-1:0]           snake_length;
   logic                                  move_tick;
   logic                                  game_over;

   modport master (
      output start, dir_req, dir_valid, grow,
      input  body_x, body_y, snake_length, move_tick, game_over
   );

   modport slave (
      input  start, dir_req, dir_valid, grow,
      output body_x, body_y, snake_length, move_tick, game_over
   );

endinterface

// File: rtl/snake_body_move_timer.sv
// Move-interval timer: down-counter that pulses wrap_c once every TICK_DIV enabled cycles.
module move_timer #(
   parameter int unsigned TICK_DIV = 2_500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic wrap_c
);

   localparam int unsigned      CNT_W   = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = CNT_TOP;
      end else if (en) begin
         cnt_d = (cnt_q == '0) ? CNT_TOP : cnt_q - CNT_W'(1);
      end
   end

   assign wrap_c = en && !clr && (cnt_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= CNT_TOP;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/snake_body.sv
// Snake movement/body-tracking stage: tick-driven shift of MAX_LEN segments with wall/self collision.
// Define SNAKE_WRAP_EN to wrap the head around the playfield edges instead of dying at the walls.
module snake_body
   import snake_pkg::*;
#(
   parameter int unsigned MAX_LEN   = 30,
   parameter int unsigned STEP      = 10,
   parameter int unsigned TICK_DIV  = 2_500_000,
   parameter int unsigned X_MIN     = 150,
   parameter int unsigned X_MAX     = 749,
   parameter int unsigned Y_MIN     = 50,
   parameter int unsigned Y_MAX     = 499,
   parameter int unsigned START_X   = 400,
   parameter int unsigned START_Y   = 300,
   parameter int unsigned START_LEN = 3
) (
   input logic         clk,
   input logic         rst,
   snake_body_if.slave bus
);

   localparam int unsigned SW = COORD_W + 1;
   localparam logic signed [SW-1:0] STEP_S = SW'(STEP);
   localparam logic signed [SW-1:0] XMIN_S = SW'(X_MIN);
   localparam logic signed [SW-1:0] XMAX_S = SW'(X_MAX);
   localparam logic signed [SW-1:0] YMIN_S = SW'(Y_MIN);
   localparam logic signed [SW-1:0] YMAX_S = SW'(Y_MAX);

   function automatic logic [COORD_W-1:0] init_x(input int unsigned i);
      return COORD_W'(START_X - i * STEP);
   endfunction

   state_e               state_q, state_d;
   dir_e                 dir_q, dir_d, pend_dir_q, pend_dir_d;
   logic                 pend_grow_q, pend_grow_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [COORD_W-1:0]   bx_q [MAX_LEN];
   logic [COORD_W-1:0]   bx_d [MAX_LEN];
   logic [COORD_W-1:0]   by_q [MAX_LEN];
   logic [COORD_W-1:0]   by_d [MAX_LEN];
   logic                 move_tick_q, move_tick_d;
   logic                 game_over_q, game_over_d;

   logic                 tick_c, init_c, grow_eff, wall_hit, self_hit;
   logic signed [SW-1:0] hx_s, hy_s, nx_s, ny_s;
   logic [COORD_W-1:0]   nhx, nhy;
   logic [LEN_W-1:0]     self_lim;

   assign init_c   = (state_q != ST_RUN) && bus.start;
   assign grow_eff = pend_grow_q || bus.grow;

   move_timer #(.TICK_DIV(TICK_DIV)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .en     (state_q == ST_RUN),
      .clr    (init_c),
      .wrap_c (tick_c)
   );

   // Next head in 11-bit signed so a step below zero stays negative.
   always_comb begin
      hx_s = $signed({1'b0, bx_q[0]});
      hy_s = $signed({1'b0, by_q[0]});
      nx_s = hx_s;
      ny_s = hy_s;
      case (pend_dir_q)
         DIR_UP:    ny_s = hy_s - STEP_S;
         DIR_RIGHT: nx_s = hx_s + STEP_S;
         DIR_DOWN:  ny_s = hy_s + STEP_S;
         default:   nx_s = hx_s - STEP_S;
      endcase
`ifdef SNAKE_WRAP_EN
      wall_hit = 1'b0;
      if (nx_s > XMAX_S)      nhx = COORD_W'(X_MIN);
      else if (nx_s < XMIN_S) nhx = COORD_W'(X_MAX);
      else                    nhx = COORD_W'(nx_s);
      if (ny_s > YMAX_S)      nhy = COORD_W'(Y_MIN);
      else if (ny_s < YMIN_S) nhy = COORD_W'(Y_MAX);
      else                    nhy = COORD_W'(ny_s);
`else
      wall_hit = (nx_s < XMIN_S) || (nx_s > XMAX_S) || (ny_s < YMIN_S) || (ny_s > YMAX_S);
      nhx      = COORD_W'(nx_s);
      nhy      = COORD_W'(ny_s);
`endif
   end

   // A pending grow keeps the tail in place, so it stays a collision target.
   always_comb begin
      self_lim = grow_eff ? len_q : len_q - LEN_W'(1);
      self_hit = 1'b0;
      for (int unsigned j = 0; j < MAX_LEN; j++) begin
         if ((LEN_W'(j) < self_lim) && (bx_q[j] == nhx) && (by_q[j] == nhy)) self_hit = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      pend_dir_d  = pend_dir_q;
      pend_grow_d = pend_grow_q;
      len_d       = len_q;
      bx_d        = bx_q;
      by_d        = by_q;
      move_tick_d = 1'b0;

      if (bus.dir_valid && (dir_e'(bus.dir_req) != reverse_dir(dir_q))) begin
         pend_dir_d = dir_e'(bus.dir_req);
      end

      case (state_q)
         ST_RUN: begin
            if (bus.grow) pend_grow_d = 1'b1;
            if (tick_c) begin
               if (wall_hit || self_hit) begin
                  state_d = ST_DEAD;
               end else begin
                  for (int unsigned i = 1; i < MAX_LEN; i++) begin
                     bx_d[i] = bx_q[i-1];
                     by_d[i] = by_q[i-1];
                  end
                  bx_d[0]     = nhx;
                  by_d[0]     = nhy;
                  dir_d       = pend_dir_q;
                  move_tick_d = 1'b1;
                  if (grow_eff) begin
                     pend_grow_d = 1'b0;
                     if (len_q < LEN_W'(MAX_LEN)) len_d = len_q + LEN_W'(1);
                  end
               end
            end
         end
         ST_IDLE, ST_DEAD: begin
            if (bus.start) begin
               state_d     = ST_RUN;
               dir_d       = DIR_RIGHT;
               pend_dir_d  = DIR_RIGHT;
               pend_grow_d = 1'b0;
               len_d       = LEN_W'(START_LEN);
               for (int unsigned i = 0; i < MAX_LEN; i++) begin
                  bx_d[i] = init_x(i);
                  by_d[i] = COORD_W'(START_Y);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      game_over_d = (state_d == ST_DEAD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         dir_q       <= DIR_RIGHT;
         pend_dir_q  <= DIR_RIGHT;
         pend_grow_q <= 1'b0;
         len_q       <= LEN_W'(START_LEN);
         move_tick_q <= 1'b0;
         game_over_q <= 1'b0;
         for (int unsigned i = 0; i < MAX_LEN; i++) begin
            bx_q[i] <= init_x(i);
            by_q[i] <= COORD_W'(START_Y);
         end
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         pend_dir_q  <= pend_dir_d;
         pend_grow_q <= pend_grow_d;
         len_q       <= len_d;
         move_tick_q <= move_tick_d;
         game_over_q <= game_over_d;
         bx_q        <= bx_d;
         by_q        <= by_d;
      end
   end

   for (genvar i = 0; i < MAX_LEN; i++) begin : g_pack
      assign bus.body_x[i*COORD_W +: COORD_W] = bx_q[i];
      assign bus.body_y[i*COORD_W +: COORD_W] = by_q[i];
   end

   assign bus.snake_length = len_q;
   assign bus.move_tick    = move_tick_q;
   assign bus.game_over    = game_over_q;

endmodule
